// File: rtl/psum_quant_writeback.sv
// Write-back stage: accepts core partial sums, quantizes them (round, saturate, optional ReLU)
// and writes them to the output memory at consecutive addresses.
module psum_quant_writeback #(
    parameter int unsigned PSUM_BW      = 32,
    parameter int unsigned OUTPUT_BW    = 8,
    parameter int unsigned OUT_MEM_ADDR = 16
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           start,
    input  logic [5:0]                     OH,
    input  logic [5:0]                     OW,
    input  logic [7:0]                     OC,
    input  logic [4:0]                     SHIFT,
    input  logic                           RELU_EN,
    output logic                           done,
    input  logic                           psum_valid,
    output logic                           psum_ready,
    input  logic signed [PSUM_BW-1:0]      psum_data,
    output logic                           out_mem_we,
    output logic [OUT_MEM_ADDR-1:0]        out_mem_addr,
    output logic signed [OUTPUT_BW-1:0]    out_mem_data
);

    localparam int unsigned CNT_W = 20;
    localparam int unsigned EXT_W = PSUM_BW + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'((64'sd1 <<< (OUTPUT_BW - 1)) - 64'sd1);
    localparam logic signed [EXT_W-1:0] SAT_MIN = EXT_W'(-(64'sd1 <<< (OUTPUT_BW - 1)));

    logic [1:0]                  state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [CNT_W-1:0]            total_q, total_d;
    logic [4:0]                  shift_q, shift_d;
    logic                        relu_q, relu_d;
    logic                        ready_q, ready_d;
    logic                        we_q, we_d;
    logic [OUT_MEM_ADDR-1:0]     addr_q, addr_d;
    logic signed [OUTPUT_BW-1:0] data_q, data_d;
    logic                        done_q, done_d;

    logic [CNT_W-1:0]            total_c;
    logic                        xfer_c;
    logic signed [EXT_W-1:0]     ext_c, rnd_c, sum_c, shr_c, sat_c;
    logic signed [OUTPUT_BW-1:0] quant_c;

    assign total_c = CNT_W'(OH) * CNT_W'(OW) * CNT_W'(OC);
    assign xfer_c  = psum_valid && ready_q;

    // Quantizer: extra headroom bit keeps the rounding add from overflowing.
    always_comb begin
        ext_c = {psum_data[PSUM_BW-1], psum_data};
        rnd_c = '0;
        if (shift_q != 5'd0) begin
            rnd_c = EXT_W'(1) << (shift_q - 5'd1);
        end
        sum_c = ext_c + rnd_c;
        shr_c = sum_c >>> shift_q;
        sat_c = shr_c;
        if (shr_c > SAT_MAX) begin
            sat_c = SAT_MAX;
        end else if (shr_c < SAT_MIN) begin
            sat_c = SAT_MIN;
        end
        if (relu_q && sat_c < 0) begin
            sat_c = '0;
        end
        quant_c = OUTPUT_BW'(sat_c);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            total_q <= '0;
            shift_q <= '0;
            relu_q  <= 1'b0;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            total_q <= total_d;
            shift_q <= shift_d;
            relu_q  <= relu_d;
            ready_q <= ready_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    // Next state; ready and done are registered from the upcoming state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        total_d = total_q;
        shift_d = shift_q;
        relu_d  = relu_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    shift_d = SHIFT;
                    relu_d  = RELU_EN;
                    total_d = total_c;
                    cnt_d   = '0;
                    state_d = (total_c == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (xfer_c) begin
                    we_d   = 1'b1;
                    addr_d = OUT_MEM_ADDR'(cnt_q);
                    data_d = quant_c;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == total_q - CNT_W'(1)) begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        ready_d = (state_d == S_RUN);
        done_d  = (state_d == S_DONE);
    end

    assign psum_ready   = ready_q;
    assign out_mem_we   = we_q;
    assign out_mem_addr = addr_q;
    assign out_mem_data = data_q;
    assign done         = done_q;

endmodule

// File: tb/tb_psum_quant_writeback.sv
// Scoreboard bench for psum_quant_writeback: a driver pushes expected writes from a
// behavioural quantizer model, a negedge monitor pops and compares every memory write.
module tb_psum_quant_writeback;

    logic               clk = 1'b0;
    logic               resetn, start, relu_en, psum_valid;
    logic [5:0]         oh, ow;
    logic [7:0]         oc;
    logic [4:0]         shift;
    logic               done, psum_ready, out_mem_we;
    logic signed [31:0] psum_data;
    logic [15:0]        out_mem_addr;
    logic signed [7:0]  out_mem_data;

    int n_cmp = 0;
    int n_fail = 0;
    int done_seen = 0;
    int done_exp = 0;
    logic [23:0] exp_q[$];      // {addr, data}
    logic [31:0] psum_src[$];   // directed psums, random when empty

    always #5 clk = ~clk;

    psum_quant_writeback dut (
        .clk(clk), .resetn(resetn), .start(start), .OH(oh), .OW(ow), .OC(oc),
        .SHIFT(shift), .RELU_EN(relu_en), .done(done), .psum_valid(psum_valid),
        .psum_ready(psum_ready), .psum_data(psum_data), .out_mem_we(out_mem_we),
        .out_mem_addr(out_mem_addr), .out_mem_data(out_mem_data)
    );

    task automatic check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: floor((p + 2^(s-1)) / 2^s), clamp to int8, optional ReLU.
    function automatic logic [7:0] model_q(input logic [31:0] raw, input int s, input bit relu);
        longint p, d, v, r;
        p = longint'($signed(raw));
        if (s == 0) begin
            r = p;
        end else begin
            d = longint'(1) << s;
            v = p + d / 2;
            r = (v >= 0) ? v / d : -((-v + d - 1) / d);
        end
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        if (relu && r < 0) r = 0;
        return 8'(r);
    endfunction

    // Monitor: every write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        logic [23:0] e;
        if (done) done_seen++;
        if (out_mem_we) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", longint'(out_mem_addr), longint'(e[23:8]));
                check("wr_data", longint'(out_mem_data), longint'($signed(e[7:0])));
            end
        end
    end

    // vmode: 0 valid held, 1 toggling, 2 random. abort_at>0 resets after that many transfers.
    task automatic run_job(input int h, input int w, input int c, input int s, input bit relu,
                           input int vmode, input int abort_at, input bit start_in_run);
        int total, k, cyc;
        bit v;
        logic [31:0] cur;
        total = h * w * c;
        @(posedge clk); #1;
        start = 1'b1; oh = 6'(h); ow = 6'(w); oc = 8'(c); shift = 5'(s); relu_en = relu;
        @(posedge clk); #1;
        start = 1'b0; oh = 6'($urandom); oc = 8'($urandom); shift = 5'($urandom);
        if (total == 0) begin
            @(negedge clk);
            check("zero_job_ready", longint'(psum_ready), 0);
            check("zero_job_done", longint'(done), 1);
            done_exp++;
            return;
        end
        k = 0; cyc = 0;
        cur = (psum_src.size() != 0) ? psum_src.pop_front() : $urandom;
        while (k < total && cyc < 1000) begin
            if (abort_at > 0 && k == abort_at) break;
            v = (vmode == 0) ? 1'b1 : (vmode == 1) ? ((cyc % 2) == 0) : 1'($urandom);
            psum_valid = v;
            psum_data = cur;
            start = (start_in_run && k == 1);
            @(negedge clk);
            if (v && psum_ready) begin
                exp_q.push_back({16'(k), model_q(cur, s, relu)});
                k++;
                cur = (psum_src.size() != 0) ? psum_src.pop_front() : $urandom;
            end
            @(posedge clk); #1;
            cyc++;
        end
        psum_valid = 1'b0; start = 1'b0;
        if (abort_at > 0) begin
            resetn = 1'b0;
            @(negedge clk);
            @(negedge clk);
            check("rst_ready", longint'(psum_ready), 0);
            check("rst_we", longint'(out_mem_we), 0);
            check("rst_addr", longint'(out_mem_addr), 0);
            check("rst_data", longint'(out_mem_data), 0);
            check("rst_done", longint'(done), 0);
            @(posedge clk); #1;
            resetn = 1'b1;
            return;
        end
        check("job_transfers", k, total);
        @(negedge clk);
        check("ready_after_last", longint'(psum_ready), 0);
        check("done_early", longint'(done), 0);
        @(negedge clk);
        check("done_pulse", longint'(done), 1);
        done_exp++;
        @(negedge clk);
        check("done_single", longint'(done), 0);
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; psum_valid = 1'b0; psum_data = '0;
        oh = '0; ow = '0; oc = '0; shift = '0; relu_en = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        check("reset_ready", longint'(psum_ready), 0);
        check("reset_we", longint'(out_mem_we), 0);
        check("reset_addr", longint'(out_mem_addr), 0);
        check("reset_data", longint'(out_mem_data), 0);
        check("reset_done", longint'(done), 0);

        // Saturation with valid held.
        psum_src = '{32'd5, -32'sd3, 32'd200, -32'sd200};
        run_job(2, 2, 1, 0, 1'b0, 0, 0, 1'b0);
        // Round half up, without and with ReLU.
        psum_src = '{32'd24, 32'd23, -32'sd24, -32'sd25};
        run_job(1, 2, 2, 4, 1'b0, 0, 0, 1'b0);
        psum_src = '{32'd24, 32'd23, -32'sd24, -32'sd25};
        run_job(2, 1, 2, 4, 1'b1, 0, 0, 1'b0);
        // Toggling valid.
        run_job(2, 2, 1, 3, 1'b0, 1, 0, 1'b0);
        // Empty jobs.
        run_job(5, 7, 0, 2, 1'b0, 0, 0, 1'b0);
        run_job(0, 3, 9, 2, 1'b1, 0, 0, 1'b0);
        // Abort after two transfers, then a fresh 1x1x1 job at the largest shift.
        run_job(2, 2, 1, 0, 1'b0, 0, 2, 1'b0);
        check("scoreboard_after_abort", exp_q.size(), 0);
        psum_src = '{32'h7FFF_FFFF};
        run_job(1, 1, 1, 31, 1'b0, 0, 0, 1'b0);
        // Start pulsed while running.
        run_job(2, 3, 2, 1, 1'b0, 0, 0, 1'b1);
        // Random jobs.
        for (int j = 0; j < 25; j++) begin
            psum_src.delete();
            if ($urandom_range(3) == 0) begin
                for (int m = 0; m < 8; m++) psum_src.push_back(32'($signed($urandom_range(600)) - 300));
            end
            run_job(int'($urandom_range(4)), int'($urandom_range(4, 1)), int'($urandom_range(5, 1)),
                    int'($urandom_range(31)), 1'($urandom), int'($urandom_range(2)), 0, 1'($urandom));
        end
        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        check("done_count", done_seen, done_exp);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/psum_quant_writeback.md
PSUM_QUANT_WRITEBACK -- requirements
Module: psum_quant_writeback

Interface
REQ-001 Parameter PSUM_BW, default 32, psum width from core.
REQ-002 Parameter OUTPUT_BW, default 8, quantized output width toward AXI side.
REQ-003 Parameter OUT_MEM_ADDR, default 16, output memory address width.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 resetn  input  1  synchronous, active-low reset.
REQ-006 start  input  1  single-cycle pulse; begins a write-back job.
REQ-007 OH  input  6  output tile height (0..63).
REQ-008 OW  input  6  output tile width (0..63).
REQ-009 OC  input  8  output channel count (0..255).
REQ-010 SHIFT  input  5  right-shift amount for quantization (0..31).
REQ-011 RELU_EN  input  1  1 = clamp negative results to 0.
REQ-012 done  output  1  one-cycle pulse at job completion.
REQ-013 psum_valid  input  1  core presents a psum.
REQ-014 psum_ready  output  1  block accepts the psum this cycle.
REQ-015 psum_data  input signed  PSUM_BW  partial sum from core.
REQ-016 out_mem_we  output  1  output memory write enable.
REQ-017 out_mem_addr  output  OUT_MEM_ADDR  output memory address.
REQ-018 out_mem_data  output signed  OUTPUT_BW  quantized value.

Function
REQ-019 FSM states IDLE, RUN, FLUSH, DONE; reset state IDLE.
REQ-020 IDLE: start=1 latches OH, OW, OC, SHIFT, RELU_EN and loads total = OH*OW*OC (up to 20 bits); start=0 stays IDLE; config inputs ignored outside this cycle.
REQ-021 start with total = 0: go to DONE directly; no psum accepted, no write.
REQ-022 start with total > 0: go to RUN, element counter cleared to 0.
REQ-023 psum_ready = 1 only in RUN; transfer occurs when psum_valid && psum_ready.
REQ-024 Each transfer increments element counter; psums arrive ordered x fastest, then y, then oc; element k written to out_mem_addr = k[OUT_MEM_ADDR-1:0] (wraps modulo 2^OUT_MEM_ADDR).
REQ-025 Transfer at cycle t produces out_mem_we = 1 with its addr/data at cycle t+1 (one register stage); out_mem_we = 0 in all other cycles.
REQ-026 Back-to-back transfers sustain one write per cycle; psum_valid low stalls without writes.
REQ-027 Transfer of element total-1 moves RUN -> FLUSH; psum_ready = 0 from the next cycle.
REQ-028 FLUSH (final write cycle) -> DONE unconditionally; DONE asserts done = 1 for one cycle -> IDLE.
REQ-029 Quantization, computed at PSUM_BW+1 bits to avoid overflow: SHIFT = 0 -> r = psum; SHIFT > 0 -> r = (psum + 2^(SHIFT-1)) >>> SHIFT (arithmetic, round half up).
REQ-030 Saturate r to [-128, 127] (generally [-2^(OUTPUT_BW-1), 2^(OUTPUT_BW-1)-1]); then if RELU_EN, negative -> 0.
REQ-031 start asserted while not IDLE is ignored; running job unaffected.

Reset
REQ-032 resetn = 0 at a rising edge: state IDLE, counters 0, done = 0, psum_ready = 0, out_mem_we = 0, out_mem_addr = 0, out_mem_data = 0.
REQ-033 Reset mid-job aborts immediately; pending write is dropped; no done pulse; next start begins a fresh job.

Verification
REQ-034 OH=2, OW=2, OC=1, SHIFT=0, valid held 1, psums 5,-3,200,-200 -> writes addr 0..3 data 5,-3,127,-128 on 4 consecutive cycles; done 2 cycles after last transfer.
REQ-035 SHIFT=4, psums 24, 23, -24, -25 -> data 2, 1, -1, -2 (round half up); with RELU_EN=1 -> 2, 1, 0, 0.
REQ-036 psum_valid toggled 1,0,1,0 over 4-element job -> writes only in cycles following transfers, addresses contiguous 0..3, psum_ready low after 4th transfer.
REQ-037 OC=0 (any OH/OW) with start -> done pulses, psum_ready never 1, no writes.
REQ-038 resetn=0 after 2 of 4 transfers -> all outputs 0 next cycle, no done; new start with 1x1x1 job, psum 0x7FFFFFFF, SHIFT=31 -> data 1 at addr 0, done.
REQ-039 start pulsed during RUN -> ignored; original job completes with correct count and single done.
